// File: rtl/instr_decode_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode_queue_if
// Brief    : Fetch-side and execute-side handshake bundle of instr_decode_queue.
//            ALU_W widens by 4 when DECODE_MEXT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface instr_decode_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
`ifdef DECODE_MEXT_EN
  parameter int ALU_W = 18,
`else
  parameter int ALU_W = 14,
`endif
  parameter int OPC_W = 11,
  parameter int EXC_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid_i;
  logic             in_ready_o;
  logic [31:0]      in_instr_i;
  logic [XLEN-1:0]  in_pc_i;
  logic [4:0]       rf_rs1_addr_o;
  logic [4:0]       rf_rs2_addr_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [XLEN-1:0]  out_pc_o;
  logic [4:0]       out_rs1_o;
  logic [4:0]       out_rs2_o;
  logic [4:0]       out_rd_o;
  logic [2:0]       out_funct3_o;
  logic [XLEN-1:0]  out_imm_o;
  logic [ALU_W-1:0] out_alu_op_o;
  logic [OPC_W-1:0] out_opcode_o;
  logic [EXC_W-1:0] out_exc_o;
  logic             flush_i;
  logic [CNT_W-1:0] count_o;

  modport slave (
    input  in_valid_i, in_instr_i, in_pc_i, out_ready_i, flush_i,
    output in_ready_o, rf_rs1_addr_o, rf_rs2_addr_o, out_valid_o, out_pc_o,
           out_rs1_o, out_rs2_o, out_rd_o, out_funct3_o, out_imm_o,
           out_alu_op_o, out_opcode_o, out_exc_o, count_o
  );

  modport master (
    output in_valid_i, in_instr_i, in_pc_i, out_ready_i, flush_i,
    input  in_ready_o, rf_rs1_addr_o, rf_rs2_addr_o, out_valid_o, out_pc_o,
           out_rs1_o, out_rs2_o, out_rd_o, out_funct3_o, out_imm_o,
           out_alu_op_o, out_opcode_o, out_exc_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/instr_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode_queue
// Brief    : RV32I decode stage feeding a DEPTH-entry FIFO of decoded bundles
//            with valid/ready handshakes and flush. DECODE_MEXT_EN adds M-ext.
// Revision : 1.0 - initial release
// ============================================================================
module instr_decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
`ifdef DECODE_MEXT_EN
  parameter int ALU_W = 18,
`else
  parameter int ALU_W = 14,
`endif
  parameter int OPC_W = 11,
  parameter int EXC_W = 4
) (
  input wire clk,
  input wire rst,
  instr_decode_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam int c_alu_add  = 0,  c_alu_sub  = 1,  c_alu_slt  = 2,  c_alu_sltu = 3;
  localparam int c_alu_xor  = 4,  c_alu_or   = 5,  c_alu_and  = 6,  c_alu_sll  = 7;
  localparam int c_alu_srl  = 8,  c_alu_sra  = 9,  c_alu_eq   = 10, c_alu_neq  = 11;
  localparam int c_alu_ge   = 12, c_alu_geu  = 13;
`ifdef DECODE_MEXT_EN
  localparam int c_alu_mul  = 14, c_alu_mulh = 15, c_alu_div  = 16, c_alu_rem  = 17;
`endif
  localparam int c_op_lui   = 0,  c_op_auipc = 1,  c_op_jal   = 2,  c_op_jalr  = 3;
  localparam int c_op_br    = 4,  c_op_load  = 5,  c_op_store = 6,  c_op_itype = 7;
  localparam int c_op_rtype = 8,  c_op_fence = 9,  c_op_sys   = 10;
  localparam int c_exc_ill  = 0,  c_exc_ecall = 1, c_exc_ebrk = 2,  c_exc_mret = 3;

  function automatic logic [ALU_W-1:0] f_alu(input logic [2:0] f3, input logic alt);
    f_alu = '0;
    case (f3)
      3'b000:  f_alu[alt ? c_alu_sub : c_alu_add] = 1'b1;
      3'b001:  f_alu[c_alu_sll]  = 1'b1;
      3'b010:  f_alu[c_alu_slt]  = 1'b1;
      3'b011:  f_alu[c_alu_sltu] = 1'b1;
      3'b100:  f_alu[c_alu_xor]  = 1'b1;
      3'b101:  f_alu[alt ? c_alu_sra : c_alu_srl] = 1'b1;
      3'b110:  f_alu[c_alu_or]   = 1'b1;
      default: f_alu[c_alu_and]  = 1'b1;
    endcase
  endfunction

  logic [31:0]      w_i;
  logic [2:0]       w_f3;
  logic [6:0]       w_f7;
  logic [31:0]      w_imm_i;
  logic [31:0]      w_imm32;
  logic [ALU_W-1:0] w_alu;
  logic [OPC_W-1:0] w_opc;
  logic [EXC_W-1:0] w_exc;

  assign w_i     = bus.in_instr_i;
  assign w_f3    = w_i[14:12];
  assign w_f7    = w_i[31:25];
  assign w_imm_i = {{20{w_i[31]}}, w_i[31:20]};

  always_comb begin
    w_alu = '0;
    w_alu[c_alu_add] = 1'b1;
    w_opc   = '0;
    w_exc   = '0;
    w_imm32 = '0;
    case (w_i[6:0])
      7'b0110111: begin w_opc[c_op_lui]   = 1'b1; w_imm32 = {w_i[31:12], 12'b0}; end
      7'b0010111: begin w_opc[c_op_auipc] = 1'b1; w_imm32 = {w_i[31:12], 12'b0}; end
      7'b1101111: begin
        w_opc[c_op_jal] = 1'b1;
        w_imm32 = {{12{w_i[31]}}, w_i[19:12], w_i[20], w_i[30:21], 1'b0};
      end
      7'b1100111: begin w_opc[c_op_jalr]  = 1'b1; w_imm32 = w_imm_i; end
      7'b1100011: begin
        w_opc[c_op_br] = 1'b1;
        w_imm32 = {{20{w_i[31]}}, w_i[7], w_i[30:25], w_i[11:8], 1'b0};
        w_alu = '0;
        case (w_f3)
          3'b000:  w_alu[c_alu_eq]   = 1'b1;
          3'b001:  w_alu[c_alu_neq]  = 1'b1;
          3'b100:  w_alu[c_alu_slt]  = 1'b1;
          3'b101:  w_alu[c_alu_ge]   = 1'b1;
          3'b110:  w_alu[c_alu_sltu] = 1'b1;
          3'b111:  w_alu[c_alu_geu]  = 1'b1;
          default: w_alu[c_alu_add]  = 1'b1;
        endcase
      end
      7'b0000011: begin w_opc[c_op_load]  = 1'b1; w_imm32 = w_imm_i; end
      7'b0100011: begin
        w_opc[c_op_store] = 1'b1;
        w_imm32 = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
      end
      7'b0010011: begin
        w_opc[c_op_itype] = 1'b1;
        w_imm32 = w_imm_i;
        // addi never becomes sub; only the right shift honours bit 30
        w_alu = f_alu(w_f3, (w_f3 == 3'b101) && w_i[30]);
        if (w_f3[1:0] == 2'b01 && w_i[25]) w_exc[c_exc_ill] = 1'b1;
      end
      7'b0110011: begin
        w_opc[c_op_rtype] = 1'b1;
        if (w_f7 == 7'b0000000 ||
            (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)))
          w_alu = f_alu(w_f3, w_f7[5]);
`ifdef DECODE_MEXT_EN
        else if (w_f7 == 7'b0000001) begin
          w_alu = '0;
          case (w_f3)
            3'b000:                 w_alu[c_alu_mul]  = 1'b1;
            3'b001, 3'b010, 3'b011: w_alu[c_alu_mulh] = 1'b1;
            3'b100, 3'b101:         w_alu[c_alu_div]  = 1'b1;
            default:                w_alu[c_alu_rem]  = 1'b1;
          endcase
        end
`endif
        else
          w_exc[c_exc_ill] = 1'b1;
      end
      7'b0001111: begin w_opc[c_op_fence] = 1'b1; w_imm32 = w_imm_i; end
      7'b1110011: begin
        w_opc[c_op_sys] = 1'b1;
        w_imm32 = w_f3[2] ? {27'b0, w_i[19:15]} : w_imm_i;
        if (w_f3 == 3'b000) begin
          case (w_i[21:20])
            2'b00:   w_exc[c_exc_ecall] = 1'b1;
            2'b01:   w_exc[c_exc_ebrk]  = 1'b1;
            2'b10:   w_exc[c_exc_mret]  = 1'b1;
            default: ;
          endcase
        end
      end
      default: w_exc[c_exc_ill] = 1'b1;
    endcase
  end

  logic [XLEN-1:0]  r_pc  [DEPTH];
  logic [4:0]       r_rs1 [DEPTH];
  logic [4:0]       r_rs2 [DEPTH];
  logic [4:0]       r_rd  [DEPTH];
  logic [2:0]       r_f3  [DEPTH];
  logic [XLEN-1:0]  r_imm [DEPTH];
  logic [ALU_W-1:0] r_alu [DEPTH];
  logic [OPC_W-1:0] r_opc [DEPTH];
  logic [EXC_W-1:0] r_exc [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_in_ready;
  logic w_out_valid;
  logic w_push;
  logic w_pop;

  assign w_in_ready  = (r_count < CNT_W'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid_i & w_in_ready & ~bus.flush_i;
  assign w_pop       = w_out_valid & bus.out_ready_i & ~bus.flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_pc[k]  <= '0;
        r_rs1[k] <= '0;
        r_rs2[k] <= '0;
        r_rd[k]  <= '0;
        r_f3[k]  <= '0;
        r_imm[k] <= '0;
        r_alu[k] <= '0;
        r_opc[k] <= '0;
        r_exc[k] <= '0;
      end
    end else if (bus.flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_pc[r_wr_ptr]  <= bus.in_pc_i;
        r_rs1[r_wr_ptr] <= w_i[19:15];
        r_rs2[r_wr_ptr] <= w_i[24:20];
        r_rd[r_wr_ptr]  <= w_i[11:7];
        r_f3[r_wr_ptr]  <= w_f3;
        r_imm[r_wr_ptr] <= XLEN'($signed(w_imm32));
        r_alu[r_wr_ptr] <= w_alu;
        r_opc[r_wr_ptr] <= w_opc;
        r_exc[r_wr_ptr] <= w_exc;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign bus.in_ready_o    = w_in_ready;
  assign bus.out_valid_o   = w_out_valid;
  assign bus.count_o       = r_count;
  assign bus.rf_rs1_addr_o = w_i[19:15];
  assign bus.rf_rs2_addr_o = w_i[24:20];
  assign bus.out_pc_o      = r_pc[r_rd_ptr];
  assign bus.out_rs1_o     = r_rs1[r_rd_ptr];
  assign bus.out_rs2_o     = r_rs2[r_rd_ptr];
  assign bus.out_rd_o      = r_rd[r_rd_ptr];
  assign bus.out_funct3_o  = r_f3[r_rd_ptr];
  assign bus.out_imm_o     = r_imm[r_rd_ptr];
  assign bus.out_alu_op_o  = r_alu[r_rd_ptr];
  assign bus.out_opcode_o  = r_opc[r_rd_ptr];
  assign bus.out_exc_o     = r_exc[r_rd_ptr];
endmodule
`default_nettype wire

// File: tb/tb_instr_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_decode_queue
// Brief    : Scoreboard bench for instr_decode_queue (DEPTH=2); honours DECODE_MEXT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_decode_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 2;
  localparam int OPC_W = 11;
  localparam int EXC_W = 4;
`ifdef DECODE_MEXT_EN
  localparam int ALU_W = 18;
`else
  localparam int ALU_W = 14;
`endif

  typedef struct {
    logic [31:0]      pc;
    logic [3:0]       exc;
    logic [ALU_W-1:0] alu;
    logic [OPC_W-1:0] opc;
    logic [4:0]       rd;
    logic [31:0]      imm;
    bit               chk_op;
    bit               chk_rd;
    bit               chk_imm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t nxt;

  always #5 clk = ~clk;

  instr_decode_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH), .ALU_W(ALU_W), .OPC_W(OPC_W), .EXC_W(EXC_W)) bus ();

  instr_decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .ALU_W(ALU_W), .OPC_W(OPC_W), .EXC_W(EXC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] exc, input int alu_b,
                              input int opc_b, input int rd, input logic [31:0] imm, input bit chk_imm);
    exp_t e;
    e.pc = pc; e.exc = exc; e.alu = '0; e.opc = '0; e.rd = '0; e.imm = imm;
    e.chk_op = (alu_b >= 0);
    e.chk_rd = (rd >= 0);
    e.chk_imm = chk_imm;
    if (alu_b >= 0) e.alu[alu_b] = 1'b1;
    if (opc_b >= 0) e.opc[opc_b] = 1'b1;
    if (rd >= 0) e.rd = rd[4:0];
    return e;
  endfunction

  // Handshakes resolve at the coming posedge; inputs are stable from posedge+1.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.flush_i) begin
        sb.delete();
      end else begin
        if (bus.out_valid_o && bus.out_ready_i) begin
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow pc=%h popped with nothing expected", bus.out_pc_o);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (bus.out_pc_o !== e.pc) begin
              failures++; $display("FAIL sb_pc got=%h exp=%h", bus.out_pc_o, e.pc);
            end
            checks++;
            if (bus.out_exc_o !== e.exc) begin
              failures++; $display("FAIL sb_exc pc=%h got=%b exp=%b", e.pc, bus.out_exc_o, e.exc);
            end
            if (e.chk_op) begin
              checks += 2;
              if (bus.out_alu_op_o !== e.alu) begin
                failures++; $display("FAIL sb_alu pc=%h got=%b exp=%b", e.pc, bus.out_alu_op_o, e.alu);
              end
              if (bus.out_opcode_o !== e.opc) begin
                failures++; $display("FAIL sb_opc pc=%h got=%b exp=%b", e.pc, bus.out_opcode_o, e.opc);
              end
            end
            if (e.chk_rd) begin
              checks++;
              if (bus.out_rd_o !== e.rd) begin
                failures++; $display("FAIL sb_rd pc=%h got=%0d exp=%0d", e.pc, bus.out_rd_o, e.rd);
              end
            end
            if (e.chk_imm) begin
              checks++;
              if (bus.out_imm_o !== e.imm) begin
                failures++; $display("FAIL sb_imm pc=%h got=%h exp=%h", e.pc, bus.out_imm_o, e.imm);
              end
            end
          end
        end
        if (bus.in_valid_i && bus.in_ready_o) sb.push_back(nxt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
    bus.in_valid_i = 1'b1;
    bus.in_instr_i = instr;
    bus.in_pc_i    = pc;
    nxt            = e;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks += 5;
    if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid_o); end
    if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%b exp=1", bus.in_ready_o); end
    if (bus.count_o !== 2'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.count_o); end
    if (bus.out_pc_o !== 32'h0) begin failures++; $display("FAIL rst_out_pc got=%h exp=0", bus.out_pc_o); end
    if (bus.out_alu_op_o !== '0) begin failures++; $display("FAIL rst_out_alu got=%b exp=0", bus.out_alu_op_o); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.in_instr_i  = 32'h0050_0093;
    bus.in_pc_i     = 32'h100;
    nxt = mk(32'h100, 4'b0000, 0, 7, 1, 32'd5, 1'b1);
    #1;
    checks += 2;
    if (bus.rf_rs1_addr_o !== 5'd0) begin failures++; $display("FAIL rf_rs1 got=%0d exp=0", bus.rf_rs1_addr_o); end
    if (bus.rf_rs2_addr_o !== 5'd5) begin failures++; $display("FAIL rf_rs2 got=%0d exp=5", bus.rf_rs2_addr_o); end
    tick();
    bus.in_valid_i = 1'b0;
    checks += 2;
    if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", bus.out_valid_o); end
    if (bus.count_o !== 2'd1) begin failures++; $display("FAIL single_count got=%0d exp=1", bus.count_o); end
    tick();
    checks++;
    if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", bus.out_valid_o); end
  endtask

  task automatic test_backpressure();
    bus.out_ready_i = 1'b0;
    send(32'h0050_0093, 32'h200, mk(32'h200, 4'b0000, 0, 7, 1, 32'd5, 1'b1));
    send(32'h0050_0093, 32'h204, mk(32'h204, 4'b0000, 0, 7, 1, 32'd5, 1'b1));
    checks += 2;
    if (bus.count_o !== 2'd2) begin failures++; $display("FAIL bp_full_count got=%0d exp=2", bus.count_o); end
    if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b exp=0", bus.in_ready_o); end
    send(32'h0050_0093, 32'h208, mk(32'h208, 4'b0000, 0, 7, 1, 32'd5, 1'b1));
    checks++;
    if (bus.count_o !== 2'd2) begin failures++; $display("FAIL bp_refuse_count got=%0d exp=2", bus.count_o); end
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    checks += 3;
    if (bus.count_o !== 2'd1) begin failures++; $display("FAIL bp_pop_count got=%0d exp=1", bus.count_o); end
    if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL bp_pop_ready got=%b exp=1", bus.in_ready_o); end
    if (bus.out_pc_o !== 32'h204) begin failures++; $display("FAIL bp_head_pc got=%h exp=204", bus.out_pc_o); end
    tick();
    bus.in_valid_i = 1'b0;
    checks++;
    if (bus.count_o !== 2'd2) begin failures++; $display("FAIL bp_third_count got=%0d exp=2", bus.count_o); end
    bus.out_ready_i = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.count_o !== 2'd0) begin failures++; $display("FAIL bp_drain_count got=%0d exp=0", bus.count_o); end
  endtask

  task automatic test_flush();
    bus.out_ready_i = 1'b0;
    send(32'h0050_0093, 32'h300, mk(32'h300, 4'b0000, 0, 7, 1, 32'd5, 1'b1));
    send(32'h0050_0093, 32'h304, mk(32'h304, 4'b0000, 0, 7, 1, 32'd5, 1'b1));
    checks++;
    if (bus.count_o !== 2'd2) begin failures++; $display("FAIL fl_pre_count got=%0d exp=2", bus.count_o); end
    bus.flush_i     = 1'b1;
    bus.out_ready_i = 1'b1;
    send(32'h0050_0093, 32'h308, mk(32'h308, 4'b0000, 0, 7, 1, 32'd5, 1'b1));
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    checks += 3;
    if (bus.count_o !== 2'd0) begin failures++; $display("FAIL fl_count got=%0d exp=0", bus.count_o); end
    if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL fl_valid got=%b exp=0", bus.out_valid_o); end
    if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL fl_ready got=%b exp=1", bus.in_ready_o); end
    tick();
    checks++;
    if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL fl_retained got=%b exp=0", bus.out_valid_o); end
  endtask

  task automatic test_decode();
    bus.out_ready_i = 1'b1;
    send(32'h0000_007F, 32'h400, mk(32'h400, 4'b0001, -1, -1, -1, 32'h0, 1'b0));
    send(32'h0200_1013, 32'h404, mk(32'h404, 4'b0001, -1, -1, -1, 32'h0, 1'b0));
    send(32'h4000_1033, 32'h408, mk(32'h408, 4'b0001, -1, -1, -1, 32'h0, 1'b0));
    send(32'h0000_0073, 32'h40C, mk(32'h40C, 4'b0010, 0, 10, 0, 32'h0, 1'b1));
    send(32'h0010_0073, 32'h410, mk(32'h410, 4'b0100, 0, 10, 0, 32'h0, 1'b0));
    send(32'h3020_0073, 32'h414, mk(32'h414, 4'b1000, 0, 10, 0, 32'h0, 1'b0));
    send(32'h4020_81B3, 32'h418, mk(32'h418, 4'b0000, 1, 8, 3, 32'h0, 1'b0));
    send(32'h4062_D233, 32'h41C, mk(32'h41C, 4'b0000, 9, 8, 4, 32'h0, 1'b0));
    send(32'h4030_D093, 32'h420, mk(32'h420, 4'b0000, 9, 7, 1, 32'h0, 1'b0));
    send(32'h0020_8463, 32'h424, mk(32'h424, 4'b0000, 10, 4, -1, 32'd8, 1'b1));
    send(32'hFE00_9EE3, 32'h428, mk(32'h428, 4'b0000, 11, 4, -1, 32'hFFFF_FFFC, 1'b1));
    send(32'h1234_52B7, 32'h42C, mk(32'h42C, 4'b0000, 0, 0, 5, 32'h1234_5000, 1'b1));
    send(32'hFE20_AE23, 32'h430, mk(32'h430, 4'b0000, 0, 6, -1, 32'hFFFF_FFFC, 1'b1));
    send(32'h0100_00EF, 32'h434, mk(32'h434, 4'b0000, 0, 2, 1, 32'd16, 1'b1));
    send(32'h3003_D073, 32'h438, mk(32'h438, 4'b0000, 0, 10, 0, 32'd7, 1'b1));
`ifdef DECODE_MEXT_EN
    send(32'h0220_8033, 32'h43C, mk(32'h43C, 4'b0000, 14, 8, 0, 32'h0, 1'b0));
`else
    send(32'h0220_8033, 32'h43C, mk(32'h43C, 4'b0001, -1, -1, -1, 32'h0, 1'b0));
`endif
    bus.in_valid_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(32'h0050_0093, 32'h1000 + 32'(4 * i), mk(32'h1000 + 32'(4 * i), 4'b0000, 0, 7, 1, 32'd5, 1'b1));
      checks++;
      if (bus.count_o !== 2'd1) begin failures++; $display("FAIL b2b_count i=%0d got=%0d exp=1", i, bus.count_o); end
    end
    bus.in_valid_i = 1'b0;
    tick();
    checks++;
    if (bus.count_o !== 2'd0) begin failures++; $display("FAIL b2b_drain got=%0d exp=0", bus.count_o); end
  endtask

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_instr_i  = 32'h0;
    bus.in_pc_i     = 32'h0;
    bus.out_ready_i = 1'b0;
    bus.flush_i     = 1'b0;
    nxt = mk(32'h0, 4'b0000, -1, -1, -1, 32'h0, 1'b0);
    test_reset();
    test_single();
    test_backpressure();
    test_flush();
    test_decode();
    test_back_to_back();
    tick();
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL sb_drain left=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
